// File: rtl/store_buffer.sv
// In-order store buffer: holds executed stores until the ROB commits them, drains
// committed stores to the data cache, and forwards store data to MEM-stage loads.
module store_buffer #(
  parameter int unsigned N               = 4,
  parameter int unsigned WORD_SIZE       = 32,
  parameter int unsigned ROB_ENTRY_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [WORD_SIZE-1:0]       st_addr,
  input  logic [WORD_SIZE-1:0]       st_data,
  input  logic                       st_byte,
  input  logic [ROB_ENTRY_WIDTH-1:0] st_rob_id,
  output logic                       full,
  output logic                       empty,
  input  logic                       sb_store_permission,
  input  logic [ROB_ENTRY_WIDTH-1:0] sb_rob_id,
  input  logic                       exception,
  output logic                       dcache_req,
  output logic [WORD_SIZE-1:0]       dcache_addr,
  output logic [WORD_SIZE-1:0]       dcache_data,
  output logic                       dcache_byte,
  input  logic                       dcache_ready,
  input  logic                       ld_valid,
  input  logic [WORD_SIZE-1:0]       ld_addr,
  input  logic                       ld_byte,
  output logic                       ld_hit,
  output logic [WORD_SIZE-1:0]       ld_data,
  output logic                       ld_stall
);
  localparam int unsigned PW = $clog2(N);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned W  = WORD_SIZE;
  localparam int unsigned RW = ROB_ENTRY_WIDTH;

  logic [N-1:0]  valid_q, valid_d, com_q, com_d, byte_q, byte_d;
  logic [W-1:0]  addr_q [N];
  logic [W-1:0]  addr_d [N];
  logic [W-1:0]  data_q [N];
  logic [W-1:0]  data_d [N];
  logic [RW-1:0] rob_q  [N];
  logic [RW-1:0] rob_d  [N];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, ncom;
  logic          push, pop;

  logic          fwd_found;
  logic [PW-1:0] fwd_idx, scan_idx;
  logic [W-1:0]  fwd_shift;

  assign full        = (count_q == CW'(N));
  assign empty       = (count_q == '0);
  assign dcache_req  = valid_q[head_q] & com_q[head_q];
  assign dcache_addr = addr_q[head_q];
  assign dcache_data = data_q[head_q];
  assign dcache_byte = byte_q[head_q];

  // Next-state: commit grants, drain pop, then either flush or insert.
  always_comb begin
    valid_d = valid_q;
    com_d   = com_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rob_d   = rob_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ncom    = '0;
    pop     = dcache_req & dcache_ready;
    push    = st_valid & ~full & ~exception;

    for (int unsigned i = 0; i < N; i++) begin
      if (sb_store_permission && valid_q[i] && !com_q[i] && rob_q[i] == sb_rob_id)
        com_d[i] = 1'b1;
    end

    if (pop) begin
      valid_d[head_q] = 1'b0;
      com_d[head_q]   = 1'b0;
      head_d          = head_q + PW'(1);
    end

    if (exception) begin
      // Committed entries are contiguous from head, so the survivors end at head+ncom.
      for (int unsigned i = 0; i < N; i++) begin
        com_d[i]   = com_d[i] & valid_d[i];
        valid_d[i] = valid_d[i] & com_d[i];
        if (valid_d[i]) ncom = ncom + CW'(1);
      end
      tail_d  = head_d + PW'(ncom);
      count_d = ncom;
    end else begin
      if (push) begin
        valid_d[tail_q] = 1'b1;
        com_d[tail_q]   = sb_store_permission && (sb_rob_id == st_rob_id);
        byte_d[tail_q]  = st_byte;
        addr_d[tail_q]  = st_addr;
        data_d[tail_q]  = st_data;
        rob_d[tail_q]   = st_rob_id;
        tail_d          = tail_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      com_q   <= '0;
      byte_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        rob_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      com_q   <= com_d;
      byte_q  <= byte_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rob_q   <= rob_d;
    end
  end

  // Forwarding: scan oldest to youngest so the last word match is the youngest store.
  always_comb begin
    fwd_found = 1'b0;
    fwd_idx   = '0;
    scan_idx  = '0;
    ld_hit    = 1'b0;
    ld_stall  = 1'b0;
    ld_data   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = head_q + PW'(k);
      if (valid_q[scan_idx] && addr_q[scan_idx][W-1:2] == ld_addr[W-1:2]) begin
        fwd_found = 1'b1;
        fwd_idx   = scan_idx;
      end
    end
    fwd_shift = data_q[fwd_idx] >> {ld_addr[1:0], 3'b000};
    if (ld_valid && fwd_found) begin
      if (!byte_q[fwd_idx]) begin
        ld_hit  = 1'b1;
        ld_data = ld_byte ? W'(fwd_shift[7:0]) : data_q[fwd_idx];
      end else if (ld_byte && addr_q[fwd_idx][1:0] == ld_addr[1:0]) begin
        ld_hit  = 1'b1;
        ld_data = W'(data_q[fwd_idx][7:0]);
      end else begin
        ld_stall = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_store_buffer;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, st_byte, sb_store_permission, exception, dcache_ready;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_rob_id, sb_rob_id;
  logic        full, empty, dcache_req, dcache_byte;
  logic [31:0] dcache_addr, dcache_data;
  logic        ld_valid, ld_byte, ld_hit, ld_stall;
  logic [31:0] ld_addr, ld_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          byt;
    logic [2:0]  rob;
    bit          com;
  } ent_t;
  ent_t mq[$];

  store_buffer #(.N(4), .WORD_SIZE(32), .ROB_ENTRY_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_byte(st_byte),
    .st_rob_id(st_rob_id), .full(full), .empty(empty),
    .sb_store_permission(sb_store_permission), .sb_rob_id(sb_rob_id), .exception(exception),
    .dcache_req(dcache_req), .dcache_addr(dcache_addr), .dcache_data(dcache_data),
    .dcache_byte(dcache_byte), .dcache_ready(dcache_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_byte(ld_byte),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall)
  );

  always #5 clk = ~clk;

  // Reference: one clock edge applied to the in-order queue of stores.
  task automatic model_apply();
    bit req_m  = (mq.size() > 0) && mq[0].com;
    bit full_m = (mq.size() == N);
    if (sb_store_permission)
      foreach (mq[i]) if (!mq[i].com && mq[i].rob == sb_rob_id) mq[i].com = 1'b1;
    if (req_m && dcache_ready) void'(mq.pop_front());
    if (exception) begin
      for (int i = mq.size() - 1; i >= 0; i--) if (!mq[i].com) mq.delete(i);
    end else if (st_valid && !full_m) begin
      mq.push_back('{addr: st_addr, data: st_data, byt: st_byte, rob: st_rob_id,
                     com: sb_store_permission && (sb_rob_id == st_rob_id)});
    end
  endtask

  task automatic idle();
    st_valid = 0; st_addr = 0; st_data = 0; st_byte = 0; st_rob_id = 0;
    sb_store_permission = 0; sb_rob_id = 0; exception = 0; dcache_ready = 0;
    ld_valid = 0; ld_addr = 0; ld_byte = 0;
  endtask

  task automatic cyc();
    model_apply();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic [31:0] a, input logic [31:0] d, input bit b, input logic [2:0] r);
    st_valid = 1; st_addr = a; st_data = d; st_byte = b; st_rob_id = r;
    cyc();
    st_valid = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    mq.delete();
    @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    mq.delete();
    #1;
    total++; if (full !== 1'b0)       begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
    total++; if (empty !== 1'b1)      begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    total++; if (dcache_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b exp=0", dcache_req); end
    total++; if (ld_hit !== 1'b0 || ld_stall !== 1'b0 || ld_data !== 32'h0)
      begin bad++; $display("FAIL reset_ld got=%0b/%0b/%h exp=0/0/0", ld_hit, ld_stall, ld_data); end
    @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      insert(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 3'(i));
      total++;
      if (full !== (i == 3)) begin bad++; $display("FAIL fill_full_%0d got=%0b exp=%0b", i, full, i == 3); end
    end
    insert(32'h110, 32'hA4, 1'b0, 3'd4);
    total++; if (full !== 1'b1 || empty !== 1'b0)
      begin bad++; $display("FAIL fill_overflow got full=%0b empty=%0b exp=1/0", full, empty); end
  endtask

  task automatic test_drain();
    sb_store_permission = 1; sb_rob_id = 0; dcache_ready = 1;
    #1;
    total++; if (dcache_req !== 1'b0) begin bad++; $display("FAIL drain_latency got=%0b exp=0", dcache_req); end
    cyc();
    sb_rob_id = 1;
    #1;
    total++; if (dcache_req !== 1'b1 || dcache_addr !== 32'h100 || dcache_data !== 32'hA0)
      begin bad++; $display("FAIL drain_first got=%0b %h %h exp=1 100 a0", dcache_req, dcache_addr, dcache_data); end
    cyc();
    sb_store_permission = 0;
    #1;
    total++; if (dcache_req !== 1'b1 || dcache_addr !== 32'h104 || dcache_data !== 32'hA1)
      begin bad++; $display("FAIL drain_second got=%0b %h %h exp=1 104 a1", dcache_req, dcache_addr, dcache_data); end
    cyc();
    total++; if (full !== 1'b0 || empty !== 1'b0 || dcache_req !== 1'b0)
      begin bad++; $display("FAIL drain_after got full=%0b empty=%0b req=%0b exp=0/0/0", full, empty, dcache_req); end
    dcache_ready = 0;
  endtask

  task automatic test_hold();
    sb_store_permission = 1; sb_rob_id = 2; dcache_ready = 0;
    cyc();
    sb_store_permission = 0;
    for (int i = 0; i < 3; i++) begin
      total++; if (dcache_req !== 1'b1 || dcache_addr !== 32'h108 || dcache_data !== 32'hA2)
        begin bad++; $display("FAIL hold_%0d got=%0b %h %h exp=1 108 a2", i, dcache_req, dcache_addr, dcache_data); end
      cyc();
    end
    dcache_ready = 1;
    cyc();
    total++; if (dcache_req !== 1'b0 || empty !== 1'b0)
      begin bad++; $display("FAIL hold_pop_one got req=%0b empty=%0b exp=0/0", dcache_req, empty); end
    sb_store_permission = 1; sb_rob_id = 3;
    cyc();
    sb_store_permission = 0;
    cyc();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL hold_drained got=%0b exp=1", empty); end
    dcache_ready = 0;
  endtask

  task automatic test_exception();
    do_reset();
    for (int i = 0; i < 3; i++) insert(32'h400 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0, 3'(i));
    sb_store_permission = 1; sb_rob_id = 0;
    cyc();
    sb_store_permission = 0;
    exception = 1; st_valid = 1; st_addr = 32'h40C; st_data = 32'hB3; st_rob_id = 3;
    cyc();
    exception = 0; st_valid = 0;
    total++; if (dcache_req !== 1'b1 || dcache_addr !== 32'h400 || empty !== 1'b0)
      begin bad++; $display("FAIL exc_survivor got=%0b %h empty=%0b exp=1 400 0", dcache_req, dcache_addr, empty); end
    sb_store_permission = 1; sb_rob_id = 4;
    insert(32'h500, 32'hC0, 1'b0, 3'd4);
    sb_store_permission = 0;
    dcache_ready = 1;
    cyc();
    total++; if (dcache_req !== 1'b1 || dcache_addr !== 32'h500 || dcache_data !== 32'hC0)
      begin bad++; $display("FAIL exc_tail got=%0b %h %h exp=1 500 c0", dcache_req, dcache_addr, dcache_data); end
    cyc();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL exc_empty got=%0b exp=1", empty); end
    dcache_ready = 0;
  endtask

  task automatic test_forward();
    insert(32'h200, 32'h11223344, 1'b0, 3'd5);
    insert(32'h200, 32'h55667788, 1'b0, 3'd6);
    ld_valid = 1; ld_byte = 1; ld_addr = 32'h202;
    #1;
    total++; if (ld_hit !== 1'b1 || ld_data !== 32'h66 || ld_stall !== 1'b0)
      begin bad++; $display("FAIL fwd_byte got=%0b %h stall=%0b exp=1 66 0", ld_hit, ld_data, ld_stall); end
    ld_byte = 0; ld_addr = 32'h200;
    #1;
    total++; if (ld_hit !== 1'b1 || ld_data !== 32'h55667788)
      begin bad++; $display("FAIL fwd_word got=%0b %h exp=1 55667788", ld_hit, ld_data); end
    ld_addr = 32'h204;
    #1;
    total++; if (ld_hit !== 1'b0 || ld_stall !== 1'b0)
      begin bad++; $display("FAIL fwd_miss got=%0b/%0b exp=0/0", ld_hit, ld_stall); end
    ld_valid = 0; ld_addr = 32'h200;
    #1;
    total++; if (ld_hit !== 1'b0 || ld_data !== 32'h0)
      begin bad++; $display("FAIL fwd_novalid got=%0b %h exp=0 0", ld_hit, ld_data); end
  endtask

  task automatic test_byte_forward();
    insert(32'h301, 32'h123456EF, 1'b1, 3'd7);
    ld_valid = 1; ld_byte = 0; ld_addr = 32'h300;
    #1;
    total++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0)
      begin bad++; $display("FAIL bfwd_word got stall=%0b hit=%0b exp=1/0", ld_stall, ld_hit); end
    ld_byte = 1; ld_addr = 32'h301;
    #1;
    total++; if (ld_hit !== 1'b1 || ld_data !== 32'hEF || ld_stall !== 1'b0)
      begin bad++; $display("FAIL bfwd_same got=%0b %h stall=%0b exp=1 ef 0", ld_hit, ld_data, ld_stall); end
    ld_addr = 32'h302;
    #1;
    total++; if (ld_stall !== 1'b1 || ld_hit !== 1'b0)
      begin bad++; $display("FAIL bfwd_diff got stall=%0b hit=%0b exp=1/0", ld_stall, ld_hit); end
    ld_valid = 0;
    exception = 1;
    cyc();
    exception = 0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL bfwd_flush got=%0b exp=1", empty); end
  endtask

  task automatic test_reset_mid_drain();
    sb_store_permission = 1; sb_rob_id = 2;
    insert(32'h700, 32'hD0, 1'b0, 3'd2);
    sb_store_permission = 0;
    total++; if (dcache_req !== 1'b1) begin bad++; $display("FAIL mid_req got=%0b exp=1", dcache_req); end
    rst = 0;
    mq.delete();
    #1;
    total++; if (dcache_req !== 1'b0 || empty !== 1'b1)
      begin bad++; $display("FAIL mid_reset got req=%0b empty=%0b exp=0/1", dcache_req, empty); end
    @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic test_random();
    logic [2:0]  next_rob = 0;
    int          m;
    bit          e_req, e_hit, e_stall, acc;
    logic [31:0] e_data;
    for (int c = 0; c < 800; c++) begin
      st_valid  = 1'($urandom_range(0, 1));
      st_byte   = 1'($urandom_range(0, 1));
      st_addr   = 32'h600 + 32'(4 * $urandom_range(0, 3)) + (st_byte ? 32'($urandom_range(0, 3)) : 32'h0);
      st_data   = $urandom;
      st_rob_id = next_rob;
      sb_store_permission = ($urandom_range(0, 2) == 0);
      sb_rob_id = st_rob_id;
      foreach (mq[i]) if (!mq[i].com) begin sb_rob_id = mq[i].rob; break; end
      exception    = ($urandom_range(0, 29) == 0);
      dcache_ready = ($urandom_range(0, 2) != 0);
      ld_valid  = 1'($urandom_range(0, 1));
      ld_byte   = 1'($urandom_range(0, 1));
      ld_addr   = 32'h600 + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
      #1;
      e_req = (mq.size() > 0) && mq[0].com;
      total++; if (full !== (mq.size() == N) || empty !== (mq.size() == 0) || dcache_req !== e_req)
        begin bad++; $display("FAIL rnd_flags c=%0d got f=%0b e=%0b r=%0b exp f=%0b e=%0b r=%0b", c,
          full, empty, dcache_req, mq.size() == N, mq.size() == 0, e_req); end
      if (e_req) begin
        total++; if (dcache_addr !== mq[0].addr || dcache_data !== mq[0].data || dcache_byte !== mq[0].byt)
          begin bad++; $display("FAIL rnd_head c=%0d got %h %h %0b exp %h %h %0b", c, dcache_addr,
            dcache_data, dcache_byte, mq[0].addr, mq[0].data, mq[0].byt); end
      end
      m = -1;
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].addr[31:2] == ld_addr[31:2]) begin m = i; break; end
      e_hit = 0; e_stall = 0; e_data = 0;
      if (ld_valid && m >= 0) begin
        if (!mq[m].byt) begin
          e_hit = 1;
          e_data = ld_byte ? ((mq[m].data >> (8 * ld_addr[1:0])) & 32'hFF) : mq[m].data;
        end else if (ld_byte && mq[m].addr[1:0] == ld_addr[1:0]) begin
          e_hit = 1;
          e_data = mq[m].data & 32'hFF;
        end else begin
          e_stall = 1;
        end
      end
      total++; if (ld_hit !== e_hit || ld_stall !== e_stall || ld_data !== e_data)
        begin bad++; $display("FAIL rnd_fwd c=%0d got %0b/%0b/%h exp %0b/%0b/%h", c,
          ld_hit, ld_stall, ld_data, e_hit, e_stall, e_data); end
      acc = st_valid && !exception && (mq.size() < N);
      cyc();
      if (acc) next_rob = next_rob + 3'd1;
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_fill();
    test_drain();
    test_hold();
    test_exception();
    test_forward();
    test_byte_forward();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
